// File: rtl/state_uart_tx.sv
// Snapshots local game state and sends it as a 13-byte 8N1 UART packet.
// The packet is SYNC, eleven state bytes, then an XOR checksum of the state bytes.
module state_uart_tx #(
    parameter int          CLKS_PER_BIT = 868,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        send,
    input  logic [1:0]  local_player_ID,
    input  logic [2:0]  game_state,
    input  logic [1:0]  player_direction,
    input  logic [7:0]  time_left,
    input  logic [9:0]  point_total,
    input  logic [3:0]  orders,
    input  logic [3:0]  player_state,
    input  logic [23:0] team_name,
    input  logic [8:0]  player_loc_x,
    input  logic [8:0]  player_loc_y,
    output logic        tx,
    output logic        busy,
    output logic        done
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic [12:0][7:0] r_buf;
    logic [12:0][7:0] w_pkt;
    logic [CW-1:0]    r_cnt;
    logic [2:0]       r_bit;
    logic [3:0]       r_byte;
    logic             w_tick;

    always_comb begin
        w_pkt     = '0;
        w_pkt[0]  = SYNC_BYTE;
        w_pkt[1]  = {1'b0, local_player_ID, game_state, player_direction};
        w_pkt[2]  = time_left;
        w_pkt[3]  = {6'b0, point_total[9:8]};
        w_pkt[4]  = point_total[7:0];
        w_pkt[5]  = {orders, player_state};
        w_pkt[6]  = team_name[23:16];
        w_pkt[7]  = team_name[15:8];
        w_pkt[8]  = team_name[7:0];
        w_pkt[9]  = {player_loc_x[8], player_loc_y[8], 6'b0};
        w_pkt[10] = player_loc_x[7:0];
        w_pkt[11] = player_loc_y[7:0];
        // checksum covers the state bytes only, not the sync byte
        w_pkt[12] = w_pkt[1] ^ w_pkt[2] ^ w_pkt[3] ^ w_pkt[4]
                  ^ w_pkt[5] ^ w_pkt[6] ^ w_pkt[7] ^ w_pkt[8]
                  ^ w_pkt[9] ^ w_pkt[10] ^ w_pkt[11];
    end

    assign w_tick = (r_cnt == LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_buf   <= '0;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    r_cnt  <= '0;
                    r_bit  <= '0;
                    r_byte <= '0;
                    if (send) begin
                        r_buf <= w_pkt;
                    end
                end
                S_START, S_DATA, S_STOP: begin
                    r_cnt <= w_tick ? '0 : r_cnt + CW'(1);
                    if (w_tick && r_state == S_DATA) begin
                        r_bit <= r_bit + 3'd1;
                    end
                    if (w_tick && r_state == S_STOP && r_byte != 4'd12) begin
                        r_byte <= r_byte + 4'd1;
                    end
                end
                default: begin
                    r_cnt  <= '0;
                    r_bit  <= '0;
                    r_byte <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        tx     = 1'b1;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_next = S_START;
                end
            end
            S_START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (w_tick) begin
                    w_next = S_DATA;
                end
            end
            S_DATA: begin
                tx   = r_buf[r_byte][r_bit];
                busy = 1'b1;
                if (w_tick && r_bit == 3'd7) begin
                    w_next = S_STOP;
                end
            end
            S_STOP: begin
                busy = 1'b1;
                if (w_tick) begin
                    w_next = (r_byte == 4'd12) ? S_DONE : S_START;
                end
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_state_uart_tx.sv
// Bench for state_uart_tx: a UART receiver model decodes tx and checks
// every byte against a scoreboard of packets built from the driven inputs.
module tb_state_uart_tx;

    localparam int CPB = 4;

    logic        clk;
    logic        rst_n;
    logic        send;
    logic [1:0]  id;
    logic [2:0]  gst;
    logic [1:0]  dir;
    logic [7:0]  tleft;
    logic [9:0]  pts;
    logic [3:0]  ord;
    logic [3:0]  pst;
    logic [23:0] team;
    logic [8:0]  xl;
    logic [8:0]  yl;
    logic        tx;
    logic        busy;
    logic        done;

    int n_chk = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    int done_cnt = 0;
    logic busy_q = 1'b0;

    logic [7:0] exp_q[$];
    logic [7:0] rx_hist[$];
    bit         rx_act = 1'b0;
    int         rx_t = 0;
    logic [7:0] rx_sh = '0;

    state_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clock           (clk),
        .reset           (rst_n),
        .send            (send),
        .local_player_ID (id),
        .game_state      (gst),
        .player_direction(dir),
        .time_left       (tleft),
        .point_total     (pts),
        .orders          (ord),
        .player_state    (pst),
        .team_name       (team),
        .player_loc_x    (xl),
        .player_loc_y    (yl),
        .tx              (tx),
        .busy            (busy),
        .done            (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic void push_exp();
        logic [7:0] b [13];
        logic [7:0] ck;
        b[0]  = 8'hA5;
        b[1]  = {1'b0, id, gst, dir};
        b[2]  = tleft;
        b[3]  = {6'b0, pts[9:8]};
        b[4]  = pts[7:0];
        b[5]  = {ord, pst};
        b[6]  = team[23:16];
        b[7]  = team[15:8];
        b[8]  = team[7:0];
        b[9]  = {xl[8], yl[8], 6'b0};
        b[10] = xl[7:0];
        b[11] = yl[7:0];
        ck = 8'h00;
        for (int i = 1; i <= 11; i++) ck ^= b[i];
        b[12] = ck;
        for (int i = 0; i < 13; i++) exp_q.push_back(b[i]);
    endfunction

    task automatic scramble();
        id    = 2'($urandom);
        gst   = 3'($urandom_range(0, 4));
        dir   = 2'($urandom);
        tleft = 8'($urandom);
        pts   = 10'($urandom);
        ord   = 4'($urandom);
        pst   = 4'($urandom);
        team  = 24'($urandom);
        xl    = 9'($urandom);
        yl    = 9'($urandom);
    endtask

    // Accepted at the posedge between the two negedges; inputs then change.
    task automatic send_pkt();
        @(negedge clk);
        send = 1'b1;
        push_exp();
        @(negedge clk);
        send = 1'b0;
        scramble();
    endtask

    task automatic wait_done(input int max);
        int n;
        n = 0;
        while (!done && n < max) begin
            @(negedge clk);
            n++;
        end
        chk("done_wait", 32'(done), 32'd1);
    endtask

    // Receiver: first negedge seeing tx low is start-bit cycle 0.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_act = 1'b0;
            rx_t   = 0;
        end else if (!rx_act) begin
            if (tx == 1'b0) begin
                rx_act = 1'b1;
                rx_t   = 0;
            end
        end else begin
            rx_t++;
            if (rx_t == CPB / 2) begin
                chk("rx_start", 32'(tx), 32'd0);
            end else if (rx_t >= CPB && rx_t < 9 * CPB &&
                         (rx_t % CPB) == CPB / 2) begin
                rx_sh[(rx_t / CPB) - 1] = tx;
            end else if (rx_t == 9 * CPB + CPB / 2) begin
                chk("rx_stop", 32'(tx), 32'd1);
                rx_hist.push_back(rx_sh);
                chk("rx_expect", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("rx_byte", 32'(rx_sh), 32'(exp_q.pop_front()));
                end
                rx_act = 1'b0;
            end
        end
    end

    // Packet timing and done pulse monitor.
    always @(negedge clk) begin
        if (busy && !busy_q) t_start = cyc;
        if (done) begin
            done_cnt++;
            chk("done_lat", 32'(cyc - t_start), 32'(130 * CPB));
            chk("done_busy", 32'(busy), 32'd0);
            chk("done_tx", 32'(tx), 32'd1);
        end
        busy_q = busy;
    end

    initial begin
        int d0;
        rst_n = 1'b0;
        send  = 1'b0;
        id = '0; gst = '0; dir = '0; tleft = '0; pts = '0;
        ord = '0; pst = '0; team = '0; xl = '0; yl = '0;
        repeat (3) @(negedge clk);
        chk("rst_state", 32'({tx, busy, done}), 32'b100);
        rst_n = 1'b1;

        repeat (50) begin
            @(negedge clk);
            chk("idle", 32'({tx, busy, done}), 32'b100);
        end

        id = 2'd1; gst = 3'd2; dir = 2'd1; tleft = 8'd150;
        pts = 10'h2C5; ord = 4'b0101; pst = 4'd3;
        team = 24'h414243; xl = 9'd304; yl = 9'd208;
        send_pkt();
        chk("accept_busy", 32'({tx, busy}), 32'b01);
        wait_done(700);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        repeat (5) begin
            @(negedge clk);
            chk("done_send_ign", 32'(busy), 32'd0);
        end

        d0 = done_cnt;
        send_pkt();
        repeat (200) @(negedge clk);
        send = 1'b1;
        @(negedge clk);
        send = 1'b0;
        wait_done(700);
        send_pkt();
        chk("reaccept", 32'(busy), 32'd1);
        wait_done(700);
        repeat (5) @(negedge clk);
        chk("one_done_each", 32'(done_cnt - d0), 32'd2);
        chk("q_empty_4", 32'(exp_q.size()), 32'd0);

        send_pkt();
        repeat (7 * 10 * CPB + 4 * CPB) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst", 32'({tx, busy, done}), 32'b100);
        send_pkt();
        wait_done(700);
        chk("q_empty_5", 32'(exp_q.size()), 32'd0);

        id = 2'd3; gst = 3'd7; dir = 2'd3; tleft = 8'hFF;
        pts = 10'h3FF; ord = 4'hF; pst = 4'hF;
        team = 24'hFFFFFF; xl = 9'd511; yl = 9'd511;
        rx_hist.delete();
        send_pkt();
        wait_done(700);
        chk("ones_len", 32'(rx_hist.size()), 32'd13);
        if (rx_hist.size() == 13) begin
            chk("ones_b3", 32'(rx_hist[3]), 32'h03);
            chk("ones_b9", 32'(rx_hist[9]), 32'hC0);
        end
        chk("q_empty_6", 32'(exp_q.size()), 32'd0);

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
